// File: rtl/act_unit_pipe.sv
// Two-stage multi-lane FP32 activation unit (identity / ReLU / LeakyReLU / ReLU6) with valid/ready flow control.
// Optional build macro ACT_UNIT_STATS_EN adds transfer and negative-lane counters.

module fp_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  // Round-to-nearest-even; subnormal inputs and underflowing results are flushed to signed zero.
  logic               sign;
  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]        prod;
  logic [22:0]        mant;
  logic               guard, sticky, round_up;
  logic [23:0]        mant_r;
  logic signed [9:0]  exp_s;

  always_comb begin
    sign   = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    fa     = a[22:0];
    fb     = b[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    prod   = 48'({1'b1, fa}) * 48'({1'b1, fb});
    exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127 + $signed({9'd0, prod[47]});
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    if (mant_r[23]) exp_s = exp_s + 10'sd1;

    p = {sign, exp_s[7:0], mant_r[22:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) p = 32'h7FC00000;
    else if (a_inf || b_inf)                                      p = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                                    p = {sign, 31'd0};
    else if (exp_s >= 10'sd255)                                   p = {sign, 8'hFF, 23'd0};
    else if (exp_s <= 10'sd0)                                     p = {sign, 31'd0};
  end
endmodule

module act_unit_pipe #(
  parameter int          LANES     = 4,
  parameter logic [31:0] SLOPE_RST = 32'h3DCCCCCD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                cfg_slope_we,
  input  logic [31:0]         cfg_slope,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*LANES-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef ACT_UNIT_STATS_EN
  input  logic                stat_clr,
  output logic [31:0]         stat_beats,
  output logic [31:0]         stat_neg,
`endif
  output logic [32*LANES-1:0] data_out
);
  logic                adv;
  logic [31:0]         slope_reg;
  logic                s1_valid_reg, s2_valid_reg;
  logic [32*LANES-1:0] s1_data_reg;
  logic [1:0]          s1_mode_reg;
  logic [31:0]         s1_slope_reg;
  logic [32*LANES-1:0] act_res;

  assign adv       = !s2_valid_reg || out_ready;
  assign in_ready  = adv;
  assign out_valid = s2_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      slope_reg    <= SLOPE_RST;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_mode_reg  <= 2'd0;
      s1_slope_reg <= SLOPE_RST;
      data_out     <= '0;
    end else begin
      if (cfg_slope_we) slope_reg <= cfg_slope;
      if (adv) begin
        s1_valid_reg <= in_valid;
        s1_data_reg  <= data_in;
        s1_mode_reg  <= mode;
        s1_slope_reg <= slope_reg;
        s2_valid_reg <= s1_valid_reg;
        data_out     <= act_res;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [31:0] x, prod, res;
      assign x = s1_data_reg[32*gi +: 32];

      fp_mul u_mul (.a(x), .b(s1_slope_reg), .p(prod));

      // Negative NaNs take the canonical quiet NaN in LeakyReLU instead of the multiplier result.
      always_comb begin
        res = x;
        case (s1_mode_reg)
          2'd1: if (x[31]) res = 32'h00000000;
          2'd2: if (x[31]) res = ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) ? 32'h7FC00000 : prod;
          2'd3: begin
            if (x[31])                          res = 32'h00000000;
            else if (x[30:0] > 31'h40C00000)    res = 32'h40C00000;
          end
          default: res = x;
        endcase
      end

      assign act_res[32*gi +: 32] = res;
    end
  endgenerate

`ifdef ACT_UNIT_STATS_EN
  logic [LANES-1:0] neg_lane;
  logic [31:0]      neg_cnt;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_neg
      assign neg_lane[gi] = data_out[32*gi+31];
    end
  endgenerate

  always_comb begin
    neg_cnt = 32'd0;
    for (int i = 0; i < LANES; i++) neg_cnt = neg_cnt + 32'(neg_lane[i]);
  end

  // Clear has priority over a coincident transfer.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_beats <= 32'd0;
      stat_neg   <= 32'd0;
    end else if (s2_valid_reg && out_ready) begin
      stat_beats <= stat_beats + 32'd1;
      stat_neg   <= stat_neg + neg_cnt;
    end
  end
`else
  // Statistics counters are not built.
`endif
endmodule

// File: tb/tb_act_unit_pipe.sv
// Directed self-checking bench for act_unit_pipe: activations, backpressure, slope update, mid-stream reset.
// The counter checks are compiled only when ACT_UNIT_STATS_EN is defined.

module tb_act_unit_pipe;
  localparam int LANES = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          mode;
  logic                cfg_slope_we;
  logic [31:0]         cfg_slope;
  logic                in_valid;
  logic                in_ready;
  logic [32*LANES-1:0] data_in;
  logic                out_valid;
  logic                out_ready;
  logic [32*LANES-1:0] data_out;
`ifdef ACT_UNIT_STATS_EN
  logic                stat_clr;
  logic [31:0]         stat_beats;
  logic [31:0]         stat_neg;
`endif

  int            n_cmp = 0;
  int            n_err = 0;
  logic [127:0]  exp_q[$];
  logic [127:0]  held;
  logic          held_v = 1'b0;

  always #5 clk = ~clk;

  act_unit_pipe #(.LANES(LANES), .SLOPE_RST(32'h3DCCCCCD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .cfg_slope_we(cfg_slope_we), .cfg_slope(cfg_slope),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef ACT_UNIT_STATS_EN
    .stat_clr(stat_clr), .stat_beats(stat_beats), .stat_neg(stat_neg),
`endif
    .data_out(data_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic send(input logic [1:0] m, input logic [127:0] d, input logic [127:0] e);
    int w = 0;
    mode = m;
    data_in = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept", 128'(in_ready), 128'd1);
    if (in_ready) exp_q.push_back(e);
    $display("send mode=%0d data=%h expect=%h", m, d, e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && w < 50) begin
      tick(1);
      w++;
    end
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  // Output monitor: scoreboard, in_ready equation and hold-under-stall checks.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      check("in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
      if (held_v && out_valid) check("hold", data_out, held);
      held_v = out_valid && !out_ready;
      held   = data_out;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 128'd1, 128'd0 + 128'(exp_q.size()));
        else begin
          $display("recv data=%h expect=%h", data_out, exp_q[0]);
          check("beat", data_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 2'd0; cfg_slope_we = 1'b0; cfg_slope = 32'd0;
    in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
`ifdef ACT_UNIT_STATS_EN
    stat_clr = 1'b0;
`endif
    tick(2);
    rst = 1'b0;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_data_out", data_out, 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);

    send(2'd2, {32'hC0000000, 32'h3F800000, 32'h80000000, 32'hFFC00000},
               {32'hBE4CCCCD, 32'h3F800000, 32'h80000000, 32'h7FC00000});
    in_valid = 1'b0;
    tick(1);
    check("latency_valid", 128'(out_valid), 128'd1);
    drain();

    send(2'd1, {32'hBF800000, 32'h40E00000, 32'h7FC00000, 32'hFF800000},
               {32'h00000000, 32'h40E00000, 32'h7FC00000, 32'h00000000});
    send(2'd3, {32'hBF800000, 32'h40E00000, 32'h7F800000, 32'h40A00000},
               {32'h00000000, 32'h40C00000, 32'h40C00000, 32'h40A00000});
    send(2'd0, {32'hFF800000, 32'h7FC00001, 32'h80000000, 32'hC0000000},
               {32'hFF800000, 32'h7FC00001, 32'h80000000, 32'hC0000000});
    send(2'd2, {32'hFF800000, 32'hBF800000, 32'h40C00000, 32'h00000000},
               {32'hFF800000, 32'hBDCCCCCD, 32'h40C00000, 32'h00000000});
    send(2'd3, {32'h40C00001, 32'h80000000, 32'h40C00000, 32'h3F800000},
               {32'h40C00000, 32'h00000000, 32'h40C00000, 32'h3F800000});
    drain();

    // Backpressure: out_ready low on cycles 3..6 while five beats stream in.
    fork
      begin
        for (int k = 0; k < 5; k++)
          send(2'd1, {4{32'h3F800000 + 32'(k)}}, {4{32'h3F800000 + 32'(k)}});
        in_valid = 1'b0;
      end
      begin
        for (int c = 1; c <= 10; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          tick(1);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Slope written in the same cycle beat A is accepted; B sees the new slope.
    cfg_slope = 32'h3F000000;
    cfg_slope_we = 1'b1;
    send(2'd2, {4{32'hC0000000}}, {4{32'hBE4CCCCD}});
    cfg_slope_we = 1'b0;
    send(2'd2, {4{32'hC0000000}}, {4{32'hBF800000}});
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(2'd0, {4{32'h11111111}}, {4{32'h11111111}});
    send(2'd0, {4{32'h22222222}}, {4{32'h22222222}});
    in_valid = 1'b0;
    check("stalled_valid", 128'(out_valid), 128'd1);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_data_out", data_out, 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    tick(4);
    check("no_stale_valid", 128'(out_valid), 128'd0);
    send(2'd2, {4{32'hC0000000}}, {4{32'hBE4CCCCD}});
    drain();

`ifdef ACT_UNIT_STATS_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send(2'd0, {32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h3F800000},
               {32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h3F800000});
    send(2'd0, {4{32'h3F800000}}, {4{32'h3F800000}});
    send(2'd0, {4{32'hBF800000}}, {4{32'hBF800000}});
    drain();
    tick(1);
    check("stat_beats", 128'(stat_beats), 128'd3);
    check("stat_neg", 128'(stat_neg), 128'd5);
    send(2'd0, {4{32'hC0000000}}, {4{32'hC0000000}});
    in_valid = 1'b0;
    tick(1);
    check("clr_beat_valid", 128'(out_valid), 128'd1);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    check("stat_beats_clr", 128'(stat_beats), 128'd0);
    check("stat_neg_clr", 128'(stat_neg), 128'd0);
    drain();
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
